cdc_in_arbiter: RTL and testbench
=================================

Name: cdc_in_arbiter

Overview:
- Shares one USB CDC IN byte channel (device-to-host) between NUM_REQ on-chip requesters, e.g. config status, debug trace and a loopback echo.
- Each requester is granted a burst, which ends on its last byte, after MAX_BURST bytes, or after an idle timeout. Grants rotate round-robin.
- Sits in the controller between the requesters and one usb_cdc in_data/in_valid/in_ready lane. Runs on the system (app) clock.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- MAX_BURST, 8, maximum bytes per grant. Matches the CDC bulk max packet size.
- IDLE_TIMEOUT, 16, cycles the granted requester may hold valid low before its grant is revoked. 0 disables the timeout.

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  synchronous active-high reset.
- req_data_i  input  NUM_REQ*8  requester bytes; requester k uses bits [8k+7:8k].
- req_valid_i  input  NUM_REQ  per-requester byte valid.
- req_last_i  input  NUM_REQ  marks the final byte of a message; sampled with valid.
- req_ready_o  output  NUM_REQ  per-requester byte accept.
- in_data_o  output  8  byte to the CDC IN channel.
- in_valid_o  output  1  in_data_o is valid.
- in_ready_i  input  1  the CDC channel accepts the byte.
- grant_o  output  NUM_REQ  one-hot grant; all zero when idle.
- busy_o  output  1  high while in the BURST state.

Behaviour:
- Reset (synchronous, reset_i high at clk_i edge):
  - state=IDLE, grant_o=0, busy_o=0, in_valid_o=0, in_data_o=0.
  - Round-robin pointer rr_last = NUM_REQ-1, so requester 0 has first priority.
  - Burst and timeout counters = 0.
  - Reset mid-burst drops any held output byte and ends the burst immediately.
- State IDLE:
  - If any req_valid_i is high, select the first valid requester searching from rr_last+1 upward, with wrap-around.
  - Next cycle: state=BURST, grant_o=one-hot(sel), counters cleared.
  - No bytes are accepted in IDLE, so arbitration latency is 1 cycle.
- State BURST:
  - req_ready_o[g] = (~in_valid_o | in_ready_i), combinational. All other req_ready_o bits are 0, and req_ready_o is 0 in IDLE.
  - Accept condition: req_valid_i[g] & req_ready_o[g].
    - On accept: in_data_o <= the byte, in_valid_o <= 1, burst_cnt increments.
  - Output register:
    - in_valid_o clears on in_ready_i & in_valid_o when no new byte is accepted in the same cycle.
    - Simultaneous drain and accept loads the new byte with no bubble.
    - Byte order per requester is preserved; no byte is dropped or duplicated.
  - Burst end → IDLE, with rr_last <= g, when any of these holds:
    - a byte is accepted with req_last_i[g]=1;
    - the accepted byte makes burst_cnt == MAX_BURST;
    - IDLE_TIMEOUT != 0, and timeout_cnt reaches IDLE_TIMEOUT.
  - timeout_cnt increments each BURST cycle with req_valid_i[g]=0 and clears on any cycle with req_valid_i[g]=1.
  - A byte still held in the output register at burst end drains normally in later cycles. in_valid_o is independent of state.
- After a burst there is always one IDLE cycle before the next grant.
  - The same requester may be re-granted only if no other requester is valid.
- Widths:
  - burst_cnt = clog2(MAX_BURST+1) bits, saturating at MAX_BURST.
  - timeout_cnt = clog2(IDLE_TIMEOUT+1) bits, minimum 1.
- in_valid_o, once high, holds in_data_o stable until in_ready_i is seen (CDC handshake rule).
- X on req_data_i of non-granted requesters must not propagate to in_data_o.

Test Plan:
- Single-requester message: req1 sends 0xA1,0xA2,0xA3 with last on 0xA3, in_ready_i=1.
  - grant_o=3'b010 one cycle after valid rises; bytes appear on consecutive cycles; back to IDLE after 0xA3; rr_last=1.
- MAX_BURST cutoff: req0 streams 20 bytes 0x00..0x13 with no last, MAX_BURST=8.
  - Grant ends after 0x07; one IDLE cycle; re-granted; bursts carry 0x08..0x0F, then 0x10..0x13.
- Round-robin: req0, req1 and req2 all valid with 2-byte messages.
  - Grant order is 0,1,2,0,…; output is req0,req0,req1,req1,req2,req2.
- Backpressure: in_ready_i low for 5 cycles mid-burst.
  - in_valid_o stays 1 and in_data_o stays stable; req_ready_o[g]=0; transfer resumes with no loss.
- Timeout: req2 is granted, sends 1 byte, then drops valid.
  - Grant is revoked after exactly 16 idle cycles; req0 (valid) is granted next.
- Reset mid-burst: reset_i pulsed while in_valid_o=1 during a req1 burst.
  - Next cycle in_valid_o=0, grant_o=0, busy_o=0; requester 0 has priority after reset.

Source files
------------

// File: rtl/cdc_in_arbiter.sv
// rtl/cdc_in_arbiter.sv - round-robin burst arbiter sharing one USB CDC IN byte lane
// Requesters win bursts ended by last byte, MAX_BURST bytes or an idle timeout.
module cdc_in_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int MAX_BURST    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW      = $clog2(MAX_BURST + 1);
  localparam int TW      = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int TO_LAST = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
  localparam int TO_CAP  = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   rr_last_q;
  logic [BW-1:0]   burst_cnt_q;
  logic [TW-1:0]   timeout_cnt_q;
  logic [7:0]      in_data_q;
  logic            in_valid_q;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic            busy;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic            out_free;
  logic            accept;
  logic            hit_max;
  logic            timeout_hit;
  logic            burst_end;

  // Search starts just past the last owner so a requester is re-granted only when alone.
  always_comb begin : rr_pick
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(rr_last_q) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!sel_found && req_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(cand);
      end
    end
  end

  assign busy       = (state_q == BURST);
  assign gnt_onehot = NUM_REQ'(1) << gidx_q;

  // Only the granted lane reaches the output mux, so X on idle lanes stays out.
  assign g_valid = req_valid_i[gidx_q];
  assign g_last  = req_last_i[gidx_q];
  assign g_data  = req_data_i[8*gidx_q +: 8];

  assign out_free    = ~in_valid_q | in_ready_i;
  assign accept      = busy & g_valid & out_free;
  assign hit_max     = accept & (burst_cnt_q == BW'(MAX_BURST - 1));
  assign timeout_hit = (IDLE_TIMEOUT != 0) & busy & ~g_valid &
                       (timeout_cnt_q == TW'(TO_LAST));
  assign burst_end   = (accept & (g_last | hit_max)) | timeout_hit;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = BURST;
      BURST:   if (burst_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      gidx_q        <= '0;
      rr_last_q     <= IW'(NUM_REQ - 1);
      burst_cnt_q   <= '0;
      timeout_cnt_q <= '0;
      in_data_q     <= 8'h00;
      in_valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (!busy && sel_found) begin
        gidx_q        <= sel_idx;
        burst_cnt_q   <= '0;
        timeout_cnt_q <= '0;
      end

      if (busy) begin
        if (accept && (burst_cnt_q != BW'(MAX_BURST))) begin
          burst_cnt_q <= burst_cnt_q + BW'(1);
        end
        if (g_valid) begin
          timeout_cnt_q <= '0;
        end else if (timeout_cnt_q != TW'(TO_CAP)) begin
          timeout_cnt_q <= timeout_cnt_q + TW'(1);
        end
        if (burst_end) begin
          rr_last_q <= gidx_q;
        end
      end

      // Output stage drains independently of the FSM; drain plus accept reloads without a bubble.
      if (accept) begin
        in_data_q  <= g_data;
        in_valid_q <= 1'b1;
      end else if (in_ready_i) begin
        in_valid_q <= 1'b0;
      end
    end
  end

  assign req_ready_o = (busy && out_free) ? gnt_onehot : '0;
  assign grant_o     = busy ? gnt_onehot : '0;
  assign busy_o      = busy;
  assign in_data_o   = in_data_q;
  assign in_valid_o  = in_valid_q;

endmodule

// File: tb/tb_cdc_in_arbiter.sv
// tb/tb_cdc_in_arbiter.sv - bench for cdc_in_arbiter: vector table, directed sequences, random vs model
module tb_cdc_in_arbiter;
  localparam int N  = 3;
  localparam int MB = 8;
  localparam int TO = 16;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic [N*8-1:0] req_data_i = '0;
  logic [N-1:0]   req_valid_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     in_data_o;
  logic           in_valid_o;
  logic           in_ready_i = 1'b0;
  logic [N-1:0]   grant_o;
  logic           busy_o;

  cdc_in_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .in_data_o(in_data_o),
    .in_valid_o(in_valid_o), .in_ready_i(in_ready_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester sources: per-lane byte buffers of {last, data}.
  logic [8:0] src_mem [N][256];
  int head [N];
  int tail [N];
  int gap [N];
  bit rand_en = 0;
  bit rdy_rand = 0;
  bit rdy_val = 1;

  // Reference model state.
  logic [7:0] exp_q[$];
  int grant_log[$];
  int dur_log[$];
  logic [7:0] out_log[$];
  int owner, last_owner, bcnt, idle, cur_dur;
  bit end_pending, prev_stall;
  logic [7:0] prev_data;
  logic [N-1:0] prev_idle_valid;

  task automatic push_src(int k, logic last, logic [7:0] d);
    src_mem[k][tail[k]] = {last, d};
    tail[k]++;
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_init();
    for (int k = 0; k < N; k++) begin
      head[k] = 0; tail[k] = 0; gap[k] = 0;
    end
    exp_q.delete(); grant_log.delete(); dur_log.delete(); out_log.delete();
    owner = -1; last_owner = N - 1; bcnt = 0; idle = 0; cur_dur = 0;
    end_pending = 0; prev_stall = 0; prev_data = 8'h00; prev_idle_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; req_valid_i = '0; req_last_i = '0; in_ready_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    model_init();
  endtask

  task automatic cycle();
    logic [N-1:0] exp_g, exp_rdy;
    int pk;
    @(negedge clk_i);
    for (int k = 0; k < N; k++) begin
      bit en;
      en = 1;
      if (rand_en) begin
        if (gap[k] > 0) begin
          gap[k]--; en = 0;
        end else begin
          en = ($urandom_range(0, 99) < 88);
          if ($urandom_range(0, 149) == 0) gap[k] = $urandom_range(10, 24);
        end
      end
      if (en && head[k] != tail[k]) begin
        req_valid_i[k] = 1'b1;
        {req_last_i[k], req_data_i[k*8 +: 8]} = src_mem[k][head[k]];
      end else begin
        req_valid_i[k] = 1'b0;
        req_last_i[k] = 1'b0;
        req_data_i[k*8 +: 8] = 8'hxx;
      end
    end
    in_ready_i = rdy_rand ? ($urandom_range(0, 9) < 7) : rdy_val;
    #1;
    check("grant_onehot", 32'($onehot0(grant_o)), 1);
    pk = -1;
    if (owner >= 0) exp_g = end_pending ? '0 : N'(1) << owner;
    else if (prev_idle_valid != '0) begin
      pk = rr_pick(prev_idle_valid, last_owner);
      exp_g = N'(1) << pk;
    end else exp_g = '0;
    check("grant", grant_o, exp_g);
    if (owner >= 0 && end_pending) begin
      last_owner = owner; dur_log.push_back(cur_dur); owner = -1;
    end else if (owner < 0 && pk >= 0) begin
      owner = pk; grant_log.push_back(pk);
      bcnt = 0; idle = 0; end_pending = 0; cur_dur = 0;
    end
    check("busy", busy_o, owner >= 0);
    if (prev_stall) begin
      check("hold_valid", in_valid_o, 1);
      check("hold_data", in_data_o, prev_data);
    end
    exp_rdy = (owner >= 0 && (!in_valid_o || in_ready_i)) ? N'(1) << owner : '0;
    check("ready", req_ready_o, exp_rdy);
    if (in_valid_o && in_ready_i) begin
      if (exp_q.size() == 0) check("spurious_out", in_data_o, 32'hFFFF_FFFF);
      else check("out_data", in_data_o, exp_q.pop_front());
      out_log.push_back(in_data_o);
    end
    for (int k = 0; k < N; k++) begin
      if (req_valid_i[k] && req_ready_o[k]) begin
        exp_q.push_back(req_data_i[k*8 +: 8]);
        head[k]++;
        if (k == owner) begin
          bcnt++;
          if (req_last_i[k] || bcnt == MB) end_pending = 1;
        end
      end
    end
    if (owner >= 0) begin
      cur_dur++;
      if (req_valid_i[owner]) idle = 0;
      else begin
        idle++;
        if (TO != 0 && idle == TO) end_pending = 1;
      end
    end
    prev_idle_valid = (owner < 0) ? req_valid_i : '0;
    prev_stall = in_valid_o && !in_ready_i;
    prev_data = in_data_o;
  endtask

  function automatic bit all_done();
    for (int k = 0; k < N; k++) if (head[k] != tail[k]) return 0;
    return (exp_q.size() == 0) && (owner < 0) && !in_valid_o;
  endfunction

  task automatic run_until_done(int bound);
    int n = 0;
    while (!all_done() && n < bound) begin
      cycle(); n++;
    end
    if (n >= bound) check("run_timeout", 0, 1);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic [7:0]   data;
    logic         rdy;
    logic [N-1:0] egrant;
    logic         ebusy;
    logic         evalid;
    logic [7:0]   edata;
    logic [N-1:0] eready;
  } tv_t;

  tv_t tv [16];

  initial begin
    tv[0]  = '{3'b010, 3'b000, 8'hA1, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000};
    tv[1]  = '{3'b010, 3'b000, 8'hA1, 1'b1, 3'b010, 1'b1, 1'b0, 8'h00, 3'b010};
    tv[2]  = '{3'b010, 3'b000, 8'hA2, 1'b1, 3'b010, 1'b1, 1'b1, 8'hA1, 3'b010};
    tv[3]  = '{3'b010, 3'b010, 8'hA3, 1'b1, 3'b010, 1'b1, 1'b1, 8'hA2, 3'b010};
    tv[4]  = '{3'b000, 3'b000, 8'h00, 1'b1, 3'b000, 1'b0, 1'b1, 8'hA3, 3'b000};
    tv[5]  = '{3'b101, 3'b000, 8'hB0, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000};
    tv[6]  = '{3'b100, 3'b000, 8'hB0, 1'b1, 3'b100, 1'b1, 1'b0, 8'h00, 3'b100};
    for (int i = 7; i < 12; i++)
      tv[i] = '{3'b100, 3'b000, 8'hB1, 1'b0, 3'b100, 1'b1, 1'b1, 8'hB0, 3'b000};
    tv[12] = '{3'b100, 3'b000, 8'hB1, 1'b1, 3'b100, 1'b1, 1'b1, 8'hB0, 3'b100};
    tv[13] = '{3'b100, 3'b100, 8'hB2, 1'b1, 3'b100, 1'b1, 1'b1, 8'hB1, 3'b100};
    tv[14] = '{3'b000, 3'b000, 8'h00, 1'b1, 3'b000, 1'b0, 1'b1, 8'hB2, 3'b000};
    tv[15] = '{3'b000, 3'b000, 8'h00, 1'b1, 3'b000, 1'b0, 1'b0, 8'h00, 3'b000};

    do_reset();
    check("rst_grant", grant_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_valid", in_valid_o, 0);
    check("rst_data", in_data_o, 0);
    check("rst_ready", req_ready_o, 0);

    // Vector table: req1 message, then rr_last=1 picks req2 over req0, then backpressure.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      req_valid_i = tv[i].valid;
      req_last_i  = tv[i].last;
      req_data_i  = {N{tv[i].data}};
      in_ready_i  = tv[i].rdy;
      #1;
      check($sformatf("tv%0d_grant", i), grant_o, tv[i].egrant);
      check($sformatf("tv%0d_busy", i), busy_o, tv[i].ebusy);
      check($sformatf("tv%0d_valid", i), in_valid_o, tv[i].evalid);
      check($sformatf("tv%0d_ready", i), req_ready_o, tv[i].eready);
      if (tv[i].evalid) check($sformatf("tv%0d_data", i), in_data_o, tv[i].edata);
    end

    // MAX_BURST cutoff: 20 bytes, no last; final partial burst ends on timeout.
    do_reset();
    rand_en = 0; rdy_rand = 0; rdy_val = 1;
    for (int i = 0; i < 20; i++) push_src(0, 1'b0, 8'(i));
    run_until_done(300);
    check("max_nout", out_log.size(), 20);
    for (int i = 0; i < 20 && i < out_log.size(); i++) check("max_order", out_log[i], i);
    check("max_ngrant", grant_log.size(), 3);
    check("max_dur0", dur_log.size() > 0 ? dur_log[0] : -1, 8);
    check("max_dur1", dur_log.size() > 1 ? dur_log[1] : -1, 8);
    check("max_dur2", dur_log.size() > 2 ? dur_log[2] : -1, 4 + TO);

    // Round-robin: every requester has two 2-byte messages.
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < N; k++)
        for (int b = 0; b < 2; b++) push_src(k, b == 1, 8'(k*16 + m*2 + b));
    run_until_done(300);
    check("rr_ngrant", grant_log.size(), 2 * N);
    for (int i = 0; i < grant_log.size() && i < 2 * N; i++) check("rr_order", grant_log[i], i % N);
    begin
      int idx = 0;
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < N; k++)
          for (int b = 0; b < 2; b++) begin
            if (idx < out_log.size()) check("rr_bytes", out_log[idx], k*16 + m*2 + b);
            idx++;
          end
      check("rr_nout", out_log.size(), idx);
    end

    // Timeout: req2 sends one byte then goes quiet; req0 shows up meanwhile.
    do_reset();
    push_src(2, 1'b0, 8'hC0);
    for (int n = 0; n < 10 && grant_log.size() == 0; n++) cycle();
    push_src(0, 1'b1, 8'hD0);
    run_until_done(300);
    check("to_ngrant", grant_log.size(), 2);
    check("to_first", grant_log.size() > 0 ? grant_log[0] : -1, 2);
    check("to_next", grant_log.size() > 1 ? grant_log[1] : -1, 0);
    check("to_dur", dur_log.size() > 0 ? dur_log[0] : -1, 1 + TO);

    // Reset mid-burst while a req1 byte is held under backpressure.
    do_reset();
    push_src(0, 1'b1, 8'hE0);
    for (int i = 0; i < 4; i++) push_src(1, 1'b0, 8'hF0 + 8'(i));
    for (int n = 0; n < 20 && grant_log.size() < 2; n++) cycle();
    cycle();
    rdy_val = 0;
    cycle();
    cycle();
    check("pre_rst_valid", in_valid_o, 1);
    check("pre_rst_grant", grant_o, 3'b010);
    rdy_val = 1;
    do_reset();
    check("mid_rst_valid", in_valid_o, 0);
    check("mid_rst_grant", grant_o, 0);
    check("mid_rst_busy", busy_o, 0);
    for (int k = 0; k < N; k++) push_src(k, 1'b1, 8'h30 + 8'(k));
    run_until_done(100);
    check("mid_rst_prio", grant_log.size() > 0 ? grant_log[0] : -1, 0);

    // Random traffic against the model.
    do_reset();
    rand_en = 1; rdy_rand = 1;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        head[k] = 0; tail[k] = 0;
        for (int m = 0; m < 6; m++) begin
          int len = $urandom_range(1, 12);
          for (int b = 0; b < len; b++) push_src(k, b == len - 1, 8'($urandom));
        end
      end
      run_until_done(5000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
